// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//
// Purpose:
//   Holds the architectural status register {Z,V,N} and the program counter,
//   and resolves conditional branches against the latched flags. The datapath
//   loads flags on compare-type ops, the decoder issues branch requests over a
//   valid/ready handshake, and instruction fetch reads pc.
//
//   A branch takes two states: IDLE accepts the request and captures the
//   condition and offset, EVAL resolves it in exactly one cycle. The result
//   (br_done/br_taken/br_err) and the redirected pc are visible in the cycle
//   after EVAL, which is also the earliest cycle a new request can be accepted.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   reset_n      in   synchronous active-low reset
//   status_in    in   ALU status {Z,V,N} (bit2=Z, bit1=V, bit0=N)
//   load_status  in   latch status_in into status_q this edge (any state)
//   pc_inc       in   sequential fetch advance (ignored while in EVAL)
//   br_valid     in   branch request valid
//   br_ready     out  unit can accept a branch request (state is IDLE)
//   br_cond      in   condition code
//   br_imm       in   signed two's-complement branch offset
//   pc           out  current program counter
//   status_q     out  latched {Z,V,N}
//   br_done      out  one-cycle pulse: branch resolved
//   br_taken     out  branch was taken, valid while br_done=1
//   br_err       out  illegal condition code, valid while br_done=1
// -----------------------------------------------------------------------------
module branch_ctrl #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       status_in,
  input  logic             load_status,
  input  logic             pc_inc,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [IMM_W-1:0] br_imm,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       status_q,
  output logic             br_done,
  output logic             br_taken,
  output logic             br_err
);

  // Condition codes; 101..111 are illegal.
  localparam logic [2:0] COND_B   = 3'b000;
  localparam logic [2:0] COND_BEQ = 3'b001;
  localparam logic [2:0] COND_BNE = 3'b010;
  localparam logic [2:0] COND_BLT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [PC_W-1:0]  pc_reg;
  logic [2:0]       status_reg;
  logic [2:0]       cond_reg;
  logic [IMM_W-1:0] imm_reg;
  logic             done_reg;
  logic             taken_reg;
  logic             err_reg;

  logic             accept;
  logic             in_eval;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             cond_true;
  logic             cond_illegal;
  logic [PC_W-1:0]  imm_ext;
  logic [PC_W-1:0]  target;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (br_valid) state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. br_ready depends on state only, so a request held high
  // during EVAL is simply not seen until the unit is back in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    br_ready = (state_reg == IDLE);
    in_eval  = (state_reg == EVAL);
    accept   = br_ready && br_valid;
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation on the latched flags. status_reg already holds any
  // load made in the acceptance cycle; a load during EVAL lands at the same
  // edge as the result and therefore does not affect this branch.
  // ---------------------------------------------------------------------------
  always_comb begin
    flag_z       = status_reg[2];
    flag_v       = status_reg[1];
    flag_n       = status_reg[0];
    cond_true    = 1'b0;
    cond_illegal = 1'b0;
    unique case (cond_reg)
      COND_B:   cond_true = 1'b1;
      COND_BEQ: cond_true = flag_z;
      COND_BNE: cond_true = !flag_z;
      COND_BLT: cond_true = flag_n ^ flag_v;
      COND_BLE: cond_true = (flag_n ^ flag_v) | flag_z;
      default:  cond_illegal = 1'b1;
    endcase
  end

  // Sign-extend (or truncate) the offset to pc width; the sum wraps mod 2^PC_W
  // in both directions.
  always_comb begin
    imm_ext = PC_W'($signed(imm_reg));
    target  = pc_reg + imm_ext;
  end

  // ---------------------------------------------------------------------------
  // Program counter. In EVAL fetch is stalled, so pc_inc has no effect there.
  // When a branch is accepted together with pc_inc, the increment happens and
  // the target is later computed from the incremented pc.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg <= '0;
    end else if (in_eval) begin
      if (cond_true && !cond_illegal) begin
        pc_reg <= target;
      end
    end else if (pc_inc) begin
      pc_reg <= pc_reg + PC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Status register, loadable in every state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status_reg <= 3'b000;
    end else if (load_status) begin
      status_reg <= status_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch request capture; the decoder is free to change br_cond/br_imm once
  // the handshake has completed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cond_reg <= 3'b000;
      imm_reg  <= '0;
    end else if (accept) begin
      cond_reg <= br_cond;
      imm_reg  <= br_imm;
    end
  end

  // ---------------------------------------------------------------------------
  // Result pulse. Cleared by reset, so a branch interrupted in EVAL never
  // reports completion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_reg  <= 1'b0;
      taken_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg  <= in_eval;
      taken_reg <= in_eval && cond_true && !cond_illegal;
      err_reg   <= in_eval && cond_illegal;
    end
  end

  assign pc       = pc_reg;
  assign status_q = status_reg;
  assign br_done  = done_reg;
  assign br_taken = taken_reg;
  assign br_err   = err_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
//
// Purpose:
//   Self-checking bench for branch_ctrl. A table of single-branch vectors
//   (start pc, flags, condition, offset, optional flag load in the acceptance
//   cycle, expected result) is applied in a loop; hand-written sequences cover
//   reset, pc wrap, flag load during EVAL, reset in EVAL and a held request.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;

  localparam int PC_W  = 9;
  localparam int IMM_W = 8;

  logic             clk;
  logic             reset_n;
  logic [2:0]       status_in;
  logic             load_status;
  logic             pc_inc;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_cond;
  logic [IMM_W-1:0] br_imm;
  logic [PC_W-1:0]  pc;
  logic [2:0]       status_q;
  logic             br_done;
  logic             br_taken;
  logic             br_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  branch_ctrl #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .status_in   (status_in),
    .load_status (load_status),
    .pc_inc      (pc_inc),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_cond     (br_cond),
    .br_imm      (br_imm),
    .pc          (pc),
    .status_q    (status_q),
    .br_done     (br_done),
    .br_taken    (br_taken),
    .br_err      (br_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]  pc0;
    logic [2:0]       st0;
    logic [2:0]       cond;
    logic [IMM_W-1:0] imm;
    logic             acc_load;
    logic [2:0]       acc_st;
    logic             exp_taken;
    logic             exp_err;
    logic [PC_W-1:0]  exp_pc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    load_status = 1'b0;
    status_in   = 3'b000;
    pc_inc      = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'b000;
    br_imm      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Reset, then advance pc to the requested value and load the flags.
  task automatic setup(input logic [PC_W-1:0] pc0, input logic [2:0] st0);
    do_reset();
    pc_inc = 1'b1;
    for (int i = 0; i < int'(pc0); i++) tick();
    pc_inc      = 1'b0;
    load_status = 1'b1;
    status_in   = st0;
    tick();
    load_status = 1'b0;
    status_in   = 3'b111;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    setup(v.pc0, v.st0);
    check($sformatf("v%0d setup pc", idx), int'(pc), int'(v.pc0));
    check($sformatf("v%0d setup ready", idx), int'(br_ready), 1);
    // acceptance cycle
    br_valid    = 1'b1;
    br_cond     = v.cond;
    br_imm      = v.imm;
    load_status = v.acc_load;
    status_in   = v.acc_st;
    tick();
    // EVAL: scramble request inputs and request a fetch advance; none of it
    // may influence the branch in flight.
    br_valid    = 1'b0;
    br_cond     = ~v.cond;
    br_imm      = ~v.imm;
    load_status = 1'b0;
    pc_inc      = 1'b1;
    check($sformatf("v%0d eval ready", idx), int'(br_ready), 0);
    check($sformatf("v%0d eval done", idx), int'(br_done), 0);
    tick();
    pc_inc = 1'b0;
    check($sformatf("v%0d done", idx), int'(br_done), 1);
    check($sformatf("v%0d taken", idx), int'(br_taken), int'(v.exp_taken));
    check($sformatf("v%0d err", idx), int'(br_err), int'(v.exp_err));
    check($sformatf("v%0d pc", idx), int'(pc), int'(v.exp_pc));
    $display("vec %0d: cond=%b imm=%h pc0=%0d -> done=%b taken=%b err=%b pc=%0d",
             idx, v.cond, v.imm, v.pc0, br_done, br_taken, br_err, pc);
    tick();
    check($sformatf("v%0d done pulse", idx), int'(br_done), 0);
  endtask

  int exp_pc_seq    [5] = '{0, 1, 11, 12, 22};
  int exp_ready_seq [5] = '{1, 0, 1, 0, 1};
  int exp_done_seq  [5] = '{0, 0, 1, 0, 1};
  int done_seen;

  initial begin
    //          pc0  st0     cond    imm    ld    acc_st  tk    err   exp_pc
    vecs[0]  = '{9'd10,  3'b100, 3'b001, 8'hFB, 1'b0, 3'b000, 1'b1, 1'b0, 9'd5};
    vecs[1]  = '{9'd10,  3'b000, 3'b001, 8'hFB, 1'b0, 3'b000, 1'b0, 1'b0, 9'd10};
    vecs[2]  = '{9'd20,  3'b001, 3'b011, 8'h04, 1'b1, 3'b011, 1'b0, 1'b0, 9'd20};
    vecs[3]  = '{9'd20,  3'b001, 3'b011, 8'h04, 1'b0, 3'b000, 1'b1, 1'b0, 9'd24};
    vecs[4]  = '{9'd20,  3'b000, 3'b011, 8'h04, 1'b1, 3'b010, 1'b1, 1'b0, 9'd24};
    vecs[5]  = '{9'd30,  3'b000, 3'b010, 8'h10, 1'b0, 3'b000, 1'b1, 1'b0, 9'd46};
    vecs[6]  = '{9'd30,  3'b100, 3'b010, 8'h10, 1'b0, 3'b000, 1'b0, 1'b0, 9'd30};
    vecs[7]  = '{9'd40,  3'b000, 3'b100, 8'h80, 1'b0, 3'b000, 1'b0, 1'b0, 9'd40};
    vecs[8]  = '{9'd40,  3'b100, 3'b100, 8'h80, 1'b0, 3'b000, 1'b1, 1'b0, 9'd424};
    vecs[9]  = '{9'd40,  3'b011, 3'b100, 8'h7F, 1'b0, 3'b000, 1'b0, 1'b0, 9'd40};
    vecs[10] = '{9'd40,  3'b010, 3'b100, 8'h7F, 1'b0, 3'b000, 1'b1, 1'b0, 9'd167};
    vecs[11] = '{9'd510, 3'b000, 3'b000, 8'h05, 1'b0, 3'b000, 1'b1, 1'b0, 9'd3};
    vecs[12] = '{9'd2,   3'b101, 3'b000, 8'hFD, 1'b0, 3'b000, 1'b1, 1'b0, 9'd511};
    vecs[13] = '{9'd7,   3'b100, 3'b110, 8'h01, 1'b0, 3'b000, 1'b0, 1'b1, 9'd7};
    vecs[14] = '{9'd7,   3'b111, 3'b101, 8'h01, 1'b0, 3'b000, 1'b0, 1'b1, 9'd7};
    vecs[15] = '{9'd7,   3'b000, 3'b111, 8'h01, 1'b0, 3'b000, 1'b0, 1'b1, 9'd7};

    // ---- Reset with busy inputs, then three increments ----
    reset_n     = 1'b0;
    load_status = 1'b1;
    status_in   = 3'b111;
    pc_inc      = 1'b1;
    br_valid    = 1'b1;
    br_cond     = 3'b000;
    br_imm      = 8'h10;
    tick();
    tick();
    idle_inputs();
    reset_n = 1'b1;
    check("reset pc", int'(pc), 0);
    check("reset status_q", int'(status_q), 0);
    check("reset ready", int'(br_ready), 1);
    check("reset done", int'(br_done), 0);
    check("reset taken", int'(br_taken), 0);
    check("reset err", int'(br_err), 0);
    $display("reset: pc=%0d status_q=%b ready=%b done=%b", pc, status_q, br_ready, br_done);
    pc_inc = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pc_inc = 1'b0;
    check("pc after 3 inc", int'(pc), 3);
    tick();
    check("pc holds", int'(pc), 3);
    $display("inc x3: pc=%0d", pc);

    // ---- Table-driven single branches ----
    for (int i = 0; i < NVEC; i++) apply_vec(i, vecs[i]);

    // ---- pc wrap on increment ----
    setup(9'd511, 3'b000);
    check("pc 511", int'(pc), 511);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("pc wrap to 0", int'(pc), 0);
    $display("wrap: pc=%0d", pc);

    // ---- Flag load during EVAL does not affect the branch in flight ----
    setup(9'd50, 3'b100);
    br_valid = 1'b1;
    br_cond  = 3'b010;
    br_imm   = 8'h08;
    tick();
    br_valid    = 1'b0;
    load_status = 1'b1;
    status_in   = 3'b000;
    tick();
    load_status = 1'b0;
    check("eval-load done", int'(br_done), 1);
    check("eval-load taken", int'(br_taken), 0);
    check("eval-load pc", int'(pc), 50);
    check("eval-load status_q", int'(status_q), 0);
    $display("eval load: done=%b taken=%b pc=%0d status_q=%b", br_done, br_taken, pc, status_q);

    // ---- Reset during EVAL discards the branch ----
    setup(9'd4, 3'b000);
    br_valid = 1'b1;
    br_cond  = 3'b000;
    br_imm   = 8'h05;
    tick();
    br_valid = 1'b0;
    check("rst-eval ready", int'(br_ready), 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst-eval done", int'(br_done), 0);
    check("rst-eval pc", int'(pc), 0);
    check("rst-eval ready after", int'(br_ready), 1);
    tick();
    check("rst-eval done later", int'(br_done), 0);
    check("rst-eval pc later", int'(pc), 0);
    $display("reset in eval: done=%b pc=%0d", br_done, pc);

    // ---- br_valid and pc_inc held high for 5 cycles ----
    do_reset();
    br_valid  = 1'b1;
    pc_inc    = 1'b1;
    br_cond   = 3'b000;
    br_imm    = 8'h0A;
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold c%0d pc", c), int'(pc), exp_pc_seq[c]);
      check($sformatf("hold c%0d ready", c), int'(br_ready), exp_ready_seq[c]);
      check($sformatf("hold c%0d done", c), int'(br_done), exp_done_seq[c]);
      if (br_done) done_seen++;
      $display("hold c%0d: pc=%0d ready=%b done=%b", c, pc, br_ready, br_done);
      tick();
    end
    br_valid = 1'b0;
    pc_inc   = 1'b0;
    check("hold resolved in window", done_seen, 2);
    // third request was accepted in the last window cycle
    check("hold c5 ready", int'(br_ready), 0);
    check("hold c5 pc", int'(pc), 23);
    tick();
    check("hold c6 done", int'(br_done), 1);
    check("hold c6 pc", int'(pc), 33);
    tick();
    check("hold c7 done", int'(br_done), 0);
    check("hold c7 ready", int'(br_ready), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
